// File: rtl/fbuf_write_arbiter.sv
// fbuf_write_arbiter: round-robin arbiter for two pixel writers plus a
// full-frame clear sequencer, driving the single framebuffer BRAM write port.
module fbuf_write_arbiter #(
    parameter int FRAME_WIDTH_SCALED  = 640,
    parameter int FRAME_HEIGHT_SCALED = 480,
    parameter int FBUF_ADDR_WIDTH     = 19,
    parameter int FBUF_DATA_WIDTH     = 8
) (
    input  logic                       s_axi_ctrl_aclk,
    input  logic                       s_axi_ctrl_aresetn,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [FBUF_ADDR_WIDTH-1:0] req0_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] req0_data,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [FBUF_ADDR_WIDTH-1:0] req1_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] req1_data,
    input  logic                       clear_start,
    input  logic [FBUF_DATA_WIDTH-1:0] clear_color,
    output logic                       clear_busy,
    output logic                       clear_done,
    output logic                       oob_drop,
    output logic                       fbuf_en_wr,
    output logic                       fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);
    localparam int DEPTH = FRAME_WIDTH_SCALED * FRAME_HEIGHT_SCALED;
    localparam logic [FBUF_ADDR_WIDTH:0]   DEPTH_W = (FBUF_ADDR_WIDTH+1)'(DEPTH);
    localparam logic [FBUF_ADDR_WIDTH-1:0] LAST    = FBUF_ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t                     state;
    logic [FBUF_ADDR_WIDTH-1:0] cnt;
    logic [FBUF_DATA_WIDTH-1:0] color;
    logic                       last_grant;
    logic                       arb_ok;
    logic [FBUF_ADDR_WIDTH-1:0] w_addr;
    logic [FBUF_DATA_WIDTH-1:0] w_data;

    // Readies are gated by reset so every output reads 0 while it is held.
    assign arb_ok     = s_axi_ctrl_aresetn && state == ARB && !clear_start;
    assign req0_ready = arb_ok && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = arb_ok && req1_valid && (!req0_valid || !last_grant);
    assign w_addr     = req1_ready ? req1_addr : req0_addr;
    assign w_data     = req1_ready ? req1_data : req0_data;

    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            state      <= ARB;
            cnt        <= '0;
            color      <= '0;
            last_grant <= 1'b1;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            oob_drop   <= 1'b0;
            fbuf_en_wr <= 1'b0;
            fbuf_wrea  <= 1'b0;
            fbuf_addr  <= '0;
            fbuf_data  <= '0;
        end else begin
            fbuf_en_wr <= 1'b0;
            fbuf_wrea  <= 1'b0;
            oob_drop   <= 1'b0;
            clear_done <= 1'b0;
            if (state == CLEAR) begin
                fbuf_en_wr <= 1'b1;
                fbuf_wrea  <= 1'b1;
                fbuf_addr  <= cnt;
                fbuf_data  <= color;
                if (cnt == LAST) begin
                    state      <= ARB;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b1;
                end else begin
                    cnt <= cnt + FBUF_ADDR_WIDTH'(1);
                end
            end else if (clear_start) begin
                state      <= CLEAR;
                cnt        <= '0;
                color      <= clear_color;
                clear_busy <= 1'b1;
            end else if (req0_ready || req1_ready) begin
                last_grant <= req1_ready;
                if ({1'b0, w_addr} < DEPTH_W) begin
                    fbuf_en_wr <= 1'b1;
                    fbuf_wrea  <= 1'b1;
                    fbuf_addr  <= w_addr;
                    fbuf_data  <= w_data;
                end else begin
                    oob_drop <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// tb_fbuf_write_arbiter: directed bench for fbuf_write_arbiter on a reduced
// 64x48 frame so the full clear fits a short run.
module tb_fbuf_write_arbiter;
    localparam int W     = 64;
    localparam int H     = 48;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          clear_start = 1'b0;
    logic [DW-1:0] clear_color = '0;
    logic          clear_busy, clear_done, oob_drop;
    logic          fbuf_en_wr, fbuf_wrea;
    logic [AW-1:0] fbuf_addr;
    logic [DW-1:0] fbuf_data;

    int checks = 0;
    int errors = 0;

    fbuf_write_arbiter #(
        .FRAME_WIDTH_SCALED(W), .FRAME_HEIGHT_SCALED(H),
        .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW)
    ) dut (
        .s_axi_ctrl_aclk(clk), .s_axi_ctrl_aresetn(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done), .oob_drop(oob_drop),
        .fbuf_en_wr(fbuf_en_wr), .fbuf_wrea(fbuf_wrea),
        .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, cyc, stray;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", fbuf_en_wr, 0);
        chk("rst_we", fbuf_wrea, 0);
        chk("rst_addr", fbuf_addr, 0);
        chk("rst_data", fbuf_data, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_oob", oob_drop, 0);
        chk("rst_r0", req0_ready, 0);
        chk("rst_r1", req1_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Contention straight after reset: grants alternate starting with req0
        req0_valid = 1'b1; req0_addr = 12'd10; req0_data = 8'h10;
        req1_valid = 1'b1; req1_addr = 12'd20; req1_data = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("cont_r0_%0d", i), req0_ready, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("cont_r1_%0d", i), req1_ready, (i % 2 == 1) ? 1 : 0);
            @(posedge clk);
            #1;
            chk($sformatf("cont_en_%0d", i), fbuf_en_wr, 1);
            chk($sformatf("cont_addr_%0d", i), fbuf_addr, (i % 2 == 0) ? 10 : 20);
            chk($sformatf("cont_data_%0d", i), fbuf_data, (i % 2 == 0) ? 8'h10 : 8'h20);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("cont_idle_en", fbuf_en_wr, 0);
        // Single requester
        req0_valid = 1'b1; req0_addr = 12'd5; req0_data = 8'hA1;
        #1;
        chk("single_r0", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("single_en", fbuf_en_wr, 1);
        chk("single_we", fbuf_wrea, 1);
        chk("single_addr", fbuf_addr, 5);
        chk("single_data", fbuf_data, 8'hA1);
        @(posedge clk);
        #1;
        chk("single_after_en", fbuf_en_wr, 0);
        chk("single_hold_addr", fbuf_addr, 5);
        chk("single_hold_data", fbuf_data, 8'hA1);
        // Out-of-range address (first address past the frame)
        req1_valid = 1'b1; req1_addr = AW'(DEPTH); req1_data = 8'h55;
        #1;
        chk("oob_r1", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        chk("oob_en", fbuf_en_wr, 0);
        chk("oob_we", fbuf_wrea, 0);
        chk("oob_pulse", oob_drop, 1);
        @(posedge clk);
        #1;
        chk("oob_pulse_end", oob_drop, 0);
        // Full clear with req0 waiting and an ignored restart mid-way
        req0_valid = 1'b1; req0_addr = 12'd7; req0_data = 8'h77;
        clear_start = 1'b1; clear_color = 8'h3C;
        #1;
        chk("clr_start_r0", req0_ready, 0);
        @(posedge clk);
        #1;
        clear_start = 1'b0; clear_color = 8'h00;
        chk("clr_busy_first", clear_busy, 1);
        chk("clr_no_write_yet", fbuf_en_wr, 0);
        chk("clr_r0_busy", req0_ready, 0);
        n = 0; bad = 0; cyc = 0;
        while (n < DEPTH && cyc < DEPTH + 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 500) begin
                clear_start = 1'b1; clear_color = 8'hFF;
            end else if (cyc == 501) begin
                clear_start = 1'b0; clear_color = 8'h00;
            end
            if (!(fbuf_en_wr && fbuf_wrea) || int'(fbuf_addr) != n || fbuf_data !== 8'h3C) bad++;
            if (n != DEPTH - 1 && (clear_busy !== 1'b1 || clear_done !== 1'b0 || req0_ready || req1_ready)) bad++;
            n++;
        end
        chk("clr_bad_cycles", bad, 0);
        chk("clr_count", n, DEPTH);
        chk("clr_done_last_addr", fbuf_addr, DEPTH - 1);
        chk("clr_done", clear_done, 1);
        chk("clr_busy_off", clear_busy, 0);
        chk("clr_resume_r0", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        chk("post_clr_en", fbuf_en_wr, 1);
        chk("post_clr_addr", fbuf_addr, 7);
        chk("post_clr_data", fbuf_data, 8'h77);
        chk("post_clr_done_end", clear_done, 0);
        @(posedge clk);
        #1;
        chk("post_clr_idle", fbuf_en_wr, 0);
        // Asynchronous reset in the middle of a clear
        clear_start = 1'b1; clear_color = 8'h11;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        cyc = 0;
        while (!(fbuf_en_wr && fbuf_addr == 12'd1000) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("mid_clr_addr", fbuf_addr, 1000);
        chk("mid_clr_busy", clear_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", fbuf_en_wr, 0);
        chk("arst_we", fbuf_wrea, 0);
        chk("arst_busy", clear_busy, 0);
        chk("arst_done", clear_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req1_valid = 1'b1; req1_addr = 12'd33; req1_data = 8'h99;
        #1;
        chk("arst_r1", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        chk("arst_wr_en", fbuf_en_wr, 1);
        chk("arst_wr_addr", fbuf_addr, 33);
        chk("arst_wr_data", fbuf_data, 8'h99);
        chk("arst_wr_busy", clear_busy, 0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (fbuf_en_wr || fbuf_wrea || clear_busy || clear_done) stray++;
        end
        chk("arst_no_resume", stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
